router_pkt_tx: RTL and testbench



---
 rtl/router_pkt_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 3-bit router input port: buffers a payload from
// the host, then sends header, payload and parity under router busy back-pressure.
module router_pkt_tx #(
  parameter int MAX_LEN    = 7,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [2:0] len,
  input  logic [2:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [2:0] tx_data,
  output logic       tx_idle,
  output logic       done,
  output logic       cmd_err,
  output logic       err_seen
);

  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]      LEN_MAX  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  function automatic logic [2:0] parity_acc(input logic [2:0] acc, input logic [2:0] word);
    return acc ^ word;
  endfunction

  state_t          r_state;
  logic [1:0]      r_dest;
  logic [2:0]      r_len;
  logic [2:0]      r_wr;
  logic [2:0]      r_rd;
  logic [2:0]      r_par;
  logic [GW-1:0]   r_gap;
  logic            r_pkt_valid;
  logic [2:0]      r_tx_data;
  logic            r_tx_idle;
  logic            r_done;
  logic            r_cmd_err;
  logic            r_err_seen;
  logic [2:0]      r_buf [MAX_LEN];

  state_t          w_state_nxt;
  logic [1:0]      w_dest_nxt;
  logic [2:0]      w_len_nxt;
  logic [2:0]      w_wr_nxt;
  logic [2:0]      w_rd_nxt;
  logic [2:0]      w_par_nxt;
  logic [GW-1:0]   w_gap_nxt;
  logic            w_pkt_valid_nxt;
  logic [2:0]      w_tx_data_nxt;
  logic            w_done_nxt;
  logic            w_cmd_err_nxt;
  logic            w_err_seen_nxt;
  logic            w_buf_we;
  logic            w_cmd_ok;
  logic [2:0]      w_rd_inc;

  assign w_cmd_ok = (dest != 2'd3) && (len != 3'd0) && ({1'b0, len} <= LEN_MAX);
  assign w_rd_inc = r_rd + 3'd1;

  // Next-state and next-output logic; busy stalls every beat-carrying state.
  always_comb begin
    w_state_nxt     = r_state;
    w_dest_nxt      = r_dest;
    w_len_nxt       = r_len;
    w_wr_nxt        = r_wr;
    w_rd_nxt        = r_rd;
    w_par_nxt       = r_par;
    w_gap_nxt       = r_gap;
    w_pkt_valid_nxt = r_pkt_valid;
    w_tx_data_nxt   = r_tx_data;
    w_done_nxt      = 1'b0;
    w_cmd_err_nxt   = 1'b0;
    w_err_seen_nxt  = r_err_seen;
    w_buf_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pkt_valid_nxt = 1'b0;
        w_tx_data_nxt   = 3'd0;
        if (start) begin
          if (w_cmd_ok) begin
            w_state_nxt    = S_LOAD;
            w_dest_nxt     = dest;
            w_len_nxt      = len;
            w_wr_nxt       = 3'd0;
            w_par_nxt      = {1'b0, dest};
            w_err_seen_nxt = 1'b0;
          end else begin
            w_cmd_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (pay_valid) begin
          w_buf_we  = 1'b1;
          w_wr_nxt  = r_wr + 3'd1;
          w_par_nxt = parity_acc(r_par, pay_data);
          if (r_wr == (r_len - 3'd1)) begin
            w_state_nxt     = S_HEADER;
            w_pkt_valid_nxt = 1'b1;
            w_tx_data_nxt   = {1'b0, r_dest};
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_HEADER: begin
        if (!busy) begin
          w_state_nxt   = S_PAYLOAD;
          w_tx_data_nxt = r_buf[0];
          w_rd_nxt      = 3'd0;
        end else begin
          w_state_nxt = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          if (r_rd == (r_len - 3'd1)) begin
            w_state_nxt     = S_PARITY;
            w_pkt_valid_nxt = 1'b0;
            w_tx_data_nxt   = r_par;
          end else begin
            w_rd_nxt      = w_rd_inc;
            w_tx_data_nxt = r_buf[w_rd_inc];
          end
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          w_state_nxt   = S_GAP;
          w_tx_data_nxt = 3'd0;
          w_gap_nxt     = '0;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_GAP: begin
        if (err) begin
          w_err_seen_nxt = 1'b1;
        end else begin
          w_err_seen_nxt = r_err_seen;
        end
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_pkt_valid_nxt = 1'b0;
        w_tx_data_nxt   = 3'd0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dest      <= 2'd0;
      r_len       <= 3'd0;
      r_wr        <= 3'd0;
      r_rd        <= 3'd0;
      r_par       <= 3'd0;
      r_gap       <= '0;
      r_pkt_valid <= 1'b0;
      r_tx_data   <= 3'd0;
      r_tx_idle   <= 1'b1;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_err_seen  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dest      <= w_dest_nxt;
      r_len       <= w_len_nxt;
      r_wr        <= w_wr_nxt;
      r_rd        <= w_rd_nxt;
      r_par       <= w_par_nxt;
      r_gap       <= w_gap_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_idle   <= (w_state_nxt == S_IDLE);
      r_done      <= w_done_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
      r_err_seen  <= w_err_seen_nxt;
    end
  end

  // Payload buffer, written in arrival order during LOAD.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_buf[i] <= 3'd0;
      end
    end else if (w_buf_we) begin
      r_buf[r_wr] <= pay_data;
    end
  end

  assign pay_ready = (r_state == S_LOAD);
  assign pkt_valid = r_pkt_valid;
  assign tx_data   = r_tx_data;
  assign tx_idle   = r_tx_idle;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;
  assign err_seen  = r_err_seen;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset, start, pay_valid, busy, err;
  logic [1:0] dest;
  logic [2:0] len, pay_data;
  logic       pay_ready, pkt_valid, tx_idle, done, cmd_err, err_seen;
  logic [2:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;

  router_pkt_tx #(.MAX_LEN(7), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .dest(dest), .len(len),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .busy(busy), .err(err), .pkt_valid(pkt_valid), .tx_data(tx_data),
    .tx_idle(tx_idle), .done(done), .cmd_err(cmd_err), .err_seen(err_seen)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [1:0] d, input logic [2:0] l);
    start = 1'b1; dest = d; len = l;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_checks++; if (pkt_valid !== 1'b0) begin n_errors++; $display("FAIL rst_pkt_valid got=%b exp=0", pkt_valid); end
    n_checks++; if (tx_data !== 3'd0) begin n_errors++; $display("FAIL rst_tx_data got=%0d exp=0", tx_data); end
    n_checks++; if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL rst_tx_idle got=%b exp=1", tx_idle); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done got=%b exp=0", done); end
    n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL rst_cmd_err got=%b exp=0", cmd_err); end
    n_checks++; if (err_seen !== 1'b0) begin n_errors++; $display("FAIL rst_err_seen got=%b exp=0", err_seen); end
    n_checks++; if (pay_ready !== 1'b0) begin n_errors++; $display("FAIL rst_pay_ready got=%b exp=0", pay_ready); end
  endtask

  task automatic test_basic();
    logic [2:0] ed [5];
    logic       ev [5];
    ed = '{3'd1, 3'd5, 3'd2, 3'd7, 3'd1};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cmd(2'd1, 3'd3);
    n_checks++; if (pay_ready !== 1'b1) begin n_errors++; $display("FAIL basic_pay_ready got=%b exp=1", pay_ready); end
    n_checks++; if (tx_idle !== 1'b0) begin n_errors++; $display("FAIL basic_tx_idle_load got=%b exp=0", tx_idle); end
    pay_valid = 1'b1;
    pay_data = 3'd5; step();
    pay_data = 3'd2; step();
    pay_data = 3'd7; step();
    pay_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (tx_data !== ed[i]) begin n_errors++; $display("FAIL basic_tx_data[%0d] got=%0d exp=%0d", i, tx_data, ed[i]); end
      n_checks++; if (pkt_valid !== ev[i]) begin n_errors++; $display("FAIL basic_pkt_valid[%0d] got=%b exp=%b", i, pkt_valid, ev[i]); end
      step();
    end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_gap1 got=%b exp=0", done); end
    step();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_gap2 got=%b exp=0", done); end
    step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL basic_done got=%b exp=1", done); end
    n_checks++; if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL basic_tx_idle_end got=%b exp=1", tx_idle); end
    n_checks++; if (err_seen !== 1'b0) begin n_errors++; $display("FAIL basic_err_seen got=%b exp=0", err_seen); end
    step();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_max_stall();
    logic [2:0] ed [9];
    int k;
    // parity = header 0 ^ (0^1^2^3^4^5^6) = 7
    ed = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    cmd(2'd0, 3'd7);
    pay_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pay_data = 3'(i);
      step();
    end
    pay_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 9; c++) begin
      busy = (c >= 3 && c < 7);
      n_checks++; if (tx_data !== ed[k]) begin n_errors++; $display("FAIL stall_tx_data[c%0d] got=%0d exp=%0d", c, tx_data, ed[k]); end
      n_checks++; if (pkt_valid !== (k < 8)) begin n_errors++; $display("FAIL stall_pkt_valid[c%0d] got=%b exp=%b", c, pkt_valid, (k < 8)); end
      if (!busy) k++;
      step();
    end
    busy = 1'b0;
    n_checks++; if (k !== 9) begin n_errors++; $display("FAIL stall_word_count got=%0d exp=9", k); end
    step(); step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL stall_done got=%b exp=1", done); end
  endtask

  task automatic test_illegal();
    cmd(2'd3, 3'd2);
    n_checks++; if (cmd_err !== 1'b1) begin n_errors++; $display("FAIL ill_dest_cmd_err got=%b exp=1", cmd_err); end
    n_checks++; if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL ill_dest_tx_idle got=%b exp=1", tx_idle); end
    n_checks++; if (pay_ready !== 1'b0) begin n_errors++; $display("FAIL ill_dest_pay_ready got=%b exp=0", pay_ready); end
    step();
    n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL ill_dest_pulse got=%b exp=0", cmd_err); end
    cmd(2'd0, 3'd0);
    n_checks++; if (cmd_err !== 1'b1) begin n_errors++; $display("FAIL ill_len_cmd_err got=%b exp=1", cmd_err); end
    n_checks++; if (pay_ready !== 1'b0) begin n_errors++; $display("FAIL ill_len_pay_ready got=%b exp=0", pay_ready); end
    step();
    n_checks++; if (cmd_err !== 1'b0) begin n_errors++; $display("FAIL ill_len_pulse got=%b exp=0", cmd_err); end
    n_checks++; if (pkt_valid !== 1'b0) begin n_errors++; $display("FAIL ill_pkt_valid got=%b exp=0", pkt_valid); end
    n_checks++; if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL ill_tx_idle got=%b exp=1", tx_idle); end
  endtask

  task automatic test_bursty();
    logic       pv [4];
    logic [2:0] ed [4];
    pv = '{1'b1, 1'b0, 1'b0, 1'b1};
    // header 2, payload 3,6, parity 2^3^6 = 7
    ed = '{3'd2, 3'd3, 3'd6, 3'd7};
    cmd(2'd2, 3'd2);
    for (int i = 0; i < 4; i++) begin
      pay_valid = pv[i];
      pay_data  = (i == 0) ? 3'd3 : 3'd6;
      step();
      if (i < 3) begin
        n_checks++; if (pkt_valid !== 1'b0) begin n_errors++; $display("FAIL burst_early_hdr[%0d] got=%b exp=0", i, pkt_valid); end
        n_checks++; if (pay_ready !== 1'b1) begin n_errors++; $display("FAIL burst_pay_ready[%0d] got=%b exp=1", i, pay_ready); end
      end
    end
    pay_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tx_data !== ed[i]) begin n_errors++; $display("FAIL burst_tx_data[%0d] got=%0d exp=%0d", i, tx_data, ed[i]); end
      n_checks++; if (pkt_valid !== (i < 3)) begin n_errors++; $display("FAIL burst_pkt_valid[%0d] got=%b exp=%b", i, pkt_valid, (i < 3)); end
      step();
    end
    step(); step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL burst_done got=%b exp=1", done); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ed [3];
    ed = '{3'd2, 3'd4, 3'd6};
    cmd(2'd1, 3'd3);
    pay_valid = 1'b1; pay_data = 3'd1;
    step(); step(); step();
    pay_valid = 1'b0;
    step();
    n_checks++; if (tx_data !== 3'd1) begin n_errors++; $display("FAIL midrst_payload got=%0d exp=1", tx_data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (pkt_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_pkt_valid got=%b exp=0", pkt_valid); end
    n_checks++; if (tx_data !== 3'd0) begin n_errors++; $display("FAIL midrst_tx_data got=%0d exp=0", tx_data); end
    n_checks++; if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL midrst_tx_idle got=%b exp=1", tx_idle); end
    cmd(2'd2, 3'd1);
    pay_valid = 1'b1; pay_data = 3'd4;
    step();
    pay_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (tx_data !== ed[i]) begin n_errors++; $display("FAIL midrst_tx_data[%0d] got=%0d exp=%0d", i, tx_data, ed[i]); end
      n_checks++; if (pkt_valid !== (i < 2)) begin n_errors++; $display("FAIL midrst_pkt_valid[%0d] got=%b exp=%b", i, pkt_valid, (i < 2)); end
      step();
    end
    step(); step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL midrst_done got=%b exp=1", done); end
  endtask

  task automatic test_router_err();
    cmd(2'd0, 3'd1);
    pay_valid = 1'b1; pay_data = 3'd3;
    step();
    pay_valid = 1'b0;
    step(); step(); step();
    err = 1'b1;
    step();
    err = 1'b0;
    n_checks++; if (err_seen !== 1'b1) begin n_errors++; $display("FAIL rerr_set got=%b exp=1", err_seen); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rerr_done_early got=%b exp=0", done); end
    step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rerr_done got=%b exp=1", done); end
    n_checks++; if (err_seen !== 1'b1) begin n_errors++; $display("FAIL rerr_at_done got=%b exp=1", err_seen); end
    step(); step();
    n_checks++; if (err_seen !== 1'b1) begin n_errors++; $display("FAIL rerr_sticky got=%b exp=1", err_seen); end
    cmd(2'd1, 3'd1);
    n_checks++; if (err_seen !== 1'b0) begin n_errors++; $display("FAIL rerr_clear got=%b exp=0", err_seen); end
    pay_valid = 1'b1; pay_data = 3'd2;
    step();
    pay_valid = 1'b0;
    n_checks++; if (tx_data !== 3'd1) begin n_errors++; $display("FAIL rerr_hdr2 got=%0d exp=1", tx_data); end
    step(); step();
    n_checks++; if (tx_data !== 3'd3) begin n_errors++; $display("FAIL rerr_parity2 got=%0d exp=3", tx_data); end
    step(); step(); step();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rerr_done2 got=%b exp=1", done); end
    n_checks++; if (err_seen !== 1'b0) begin n_errors++; $display("FAIL rerr_clean2 got=%b exp=0", err_seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pay_valid = 1'b0; busy = 1'b0; err = 1'b0;
    dest = 2'd0; len = 3'd0; pay_data = 3'd0;
    test_reset();
    test_basic();
    test_max_stall();
    test_illegal();
    test_bursty();
    test_reset_mid();
    test_router_err();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
